// File: rtl/simplez_pkg.sv
// Shared Simplez definitions: bus widths, opcodes, I/O map and the UART
// transmitter state encoding used by the serial output peripheral.
package simplez_pkg;

   localparam int ADDRW = 9;
   localparam int DATAW = 12;

   localparam logic [2:0] OP_ST   = 3'd0;
   localparam logic [2:0] OP_LD   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_BR   = 3'd3;
   localparam logic [2:0] OP_BZ   = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_DEC  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   // I/O registers live at the top of the 512-word map
   localparam logic [ADDRW-1:0] ADDR_TXDATA = 9'd508;
   localparam logic [ADDRW-1:0] ADDR_TXSTAT = 9'd509;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   function automatic logic [DATAW-1:0] zext_byte(input logic [7:0] b);
      return {{(DATAW-8){1'b0}}, b};
   endfunction

endpackage

// File: rtl/simplez_uart_tx_port_if.sv
// CPU external bus as seen by a memory-mapped Simplez peripheral.
interface simplez_uart_tx_port_if;
   import simplez_pkg::*;

   logic [ADDRW-1:0] addr;
   logic             wr;
   logic             rd;
   logic [DATAW-1:0] data_in;
   logic [DATAW-1:0] data_out;
   logic             hit;

   modport master (output addr, wr, rd, data_in, input  data_out, hit);
   modport slave  (input  addr, wr, rd, data_in, output data_out, hit);

endinterface

// File: rtl/simplez_baud_tick.sv
// Bit-period timer: reload to BAUD_DIV-1 on load, count down while enabled,
// tick for the clock in which the count sits at zero.
module simplez_baud_tick #(
   parameter int BAUD_DIV = 104
) (
   input  logic clk,
   input  logic rstn,
   input  logic load,
   input  logic en,
   output logic tick
);

   localparam int              CW     = $clog2(BAUD_DIV);
   localparam logic [CW-1:0]   RELOAD = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(negedge clk) begin
      if (!rstn)
         cnt <= '0;
      else if (load)
         cnt <= RELOAD;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign tick = en && (cnt == '0);

endmodule

// File: rtl/simplez_uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter for the Simplez bus (TXDATA/TXSTAT).
// Define SIMPLEZ_TX_HOLD_EN to add a one-byte hold register behind the shifter.
module simplez_uart_tx_port #(
   parameter int                              BAUD_DIV    = 104,
   parameter logic [simplez_pkg::ADDRW-1:0]   ADDR_TXDATA = simplez_pkg::ADDR_TXDATA,
   parameter logic [simplez_pkg::ADDRW-1:0]   ADDR_TXSTAT = simplez_pkg::ADDR_TXSTAT
) (
   input  logic                  clk,
   input  logic                  rstn,
   simplez_uart_tx_port_if.slave bus,
   output logic                  tx,
   output logic                  busy
);
   import simplez_pkg::*;

   logic [1:0]       state;
   logic [7:0]       shreg;
   logic [2:0]       bit_cnt;
   logic [7:0]       last_byte;
   logic             overrun;
   logic             hit_q;
   logic [DATAW-1:0] data_q;

   logic       sel_data, sel_stat, wr_data, wr_stat;
   logic       ready, accept, start_idle, stop_end;
   logic       load, tick;
   logic [7:0] wr_byte;
   logic       unused_hi;

`ifdef SIMPLEZ_TX_HOLD_EN
   logic [7:0] hold_byte;
   logic       hold_full;
   logic       hold_fill;
`endif

   assign sel_data  = (bus.addr == ADDR_TXDATA);
   assign sel_stat  = (bus.addr == ADDR_TXSTAT);
   assign wr_data   = bus.wr && sel_data;
   assign wr_stat   = bus.wr && sel_stat;
   assign wr_byte   = bus.data_in[7:0];
   assign unused_hi = ^bus.data_in[DATAW-1:8];

   assign busy       = (state != TX_IDLE);
   assign stop_end   = (state == TX_STOP) && tick;

`ifdef SIMPLEZ_TX_HOLD_EN
   assign ready      = !hold_full;
   // A byte arriving on the stop-bit's last edge goes straight to the shifter
   assign hold_fill  = accept && busy && !stop_end;
`else
   assign ready      = !busy;
`endif

   assign accept     = wr_data && ready;
   assign start_idle = accept && (state == TX_IDLE);
   assign load       = start_idle || tick;

   simplez_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk  (clk),
      .rstn (rstn),
      .load (load),
      .en   (busy),
      .tick (tick)
   );

   // NOTE: tx gets a default before the case so no latch is inferred.
   always_comb begin
      tx = 1'b1;
      case (state)
         TX_START: tx = 1'b0;
         TX_DATA:  tx = shreg[0];
         default:  tx = 1'b1;
      endcase
   end

   always_ff @(negedge clk) begin
      if (!rstn) begin
         state     <= TX_IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         last_byte <= '0;
         overrun   <= 1'b0;
         hit_q     <= 1'b0;
         data_q    <= '0;
`ifdef SIMPLEZ_TX_HOLD_EN
         hold_byte <= '0;
         hold_full <= 1'b0;
`endif
      end else begin
         if (wr_data)
            last_byte <= wr_byte;

         // Set beats clear when both land on the same edge
         if (wr_data && !ready)
            overrun <= 1'b1;
         else if (wr_stat)
            overrun <= 1'b0;

         hit_q <= bus.rd && (sel_data || sel_stat);
         if (bus.rd && sel_data)
            data_q <= zext_byte(last_byte);
         else if (bus.rd && sel_stat)
            data_q <= {{(DATAW-2){1'b0}}, overrun, ready};

`ifdef SIMPLEZ_TX_HOLD_EN
         if (hold_fill) begin
            hold_byte <= wr_byte;
            hold_full <= 1'b1;
         end else if (stop_end) begin
            hold_full <= 1'b0;
         end
`endif

         case (state)
            TX_IDLE: begin
               if (accept) begin
                  shreg <= wr_byte;
                  state <= TX_START;
               end
            end
            TX_START: begin
               if (tick) begin
                  bit_cnt <= '0;
                  state   <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tick) begin
                  shreg   <= {1'b0, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= TX_STOP;
               end
            end
            default: begin
               if (tick) begin
`ifdef SIMPLEZ_TX_HOLD_EN
                  if (hold_full) begin
                     shreg <= hold_byte;
                     state <= TX_START;
                  end else if (accept) begin
                     shreg <= wr_byte;
                     state <= TX_START;
                  end else begin
                     state <= TX_IDLE;
                  end
`else
                  state <= TX_IDLE;
`endif
               end
            end
         endcase
      end
   end

   assign bus.hit      = hit_q;
   assign bus.data_out = data_q;

endmodule

// File: doc/simplez_uart_tx_port.md
Name: simplez_uart_tx_port

Overview:
- Memory-mapped serial output peripheral for the Simplez microcontroller. It sits on the CPU's external address/data bus beside main memory and consumes ST writes.
- Decodes two I/O addresses at the top of the 512-word map: a transmit data register and a status register. Data written to it is sent as 8N1 UART frames on the tx pin.
- Read data and hit flag feed the CPU's data-bus mux in place of memory output.

Parameters:
- ADDRW, 9, address bus width.
- DATAW, 12, data bus width.
- BAUD_DIV, 104, clocks per bit (12 MHz / 115200); must be >= 2.
- ADDR_TXDATA, 9'd508, transmit data register address.
- ADDR_TXSTAT, 9'd509, status register address.

Ports:
- clk  in  1  system clock; all state updates on negedge clk, same as the CPU datapath.
- rstn  in  1  reset, synchronous, active-low.
- addr  in  ADDRW  address from CPU RA register.
- wr  in  1  write strobe (CPU esc), sampled on the clock edge.
- rd  in  1  read strobe (CPU lec).
- data_in  in  DATAW  CPU write data (AC via busD).
- data_out  out  DATAW  registered read data.
- hit  out  1  registered; 1 when the previous-edge read addressed this block; bus mux selects data_out over memory.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress.

Behaviour:
- Reset (rstn=0 at an edge):
  - FSM goes to IDLE; tx=1, busy=0, hit=0, data_out=0, overrun=0.
  - Baud counter, bit counter and shift register are cleared.
  - Hold register is empty (feature on).
  - Reset mid-frame aborts the frame; tx=1 after that same edge.
- Address decode: exact compare on all ADDRW bits. Any other address has no effect; hit=0.
- Read latency is 1 edge, matching synchronous memory:
  - rd && addr==ADDR_TXDATA: data_out <= {4'b0, last written byte}.
  - rd && addr==ADDR_TXSTAT: data_out <= {10'b0, overrun, ready}.
  - hit <= rd && (either address). When there is no hit, data_out holds its value.
- Write to ADDR_TXDATA (wr=1): data_in[7:0] is taken; data_in[11:8] is ignored.
  - IDLE: shifter is loaded, FSM goes to START, busy=1 at that edge.
  - Busy and the byte cannot be accepted: the byte is dropped and overrun <= 1.
- Write to ADDR_TXSTAT: clears overrun; data value is ignored.
- Simultaneous events:
  - Write to TXSTAT on the same edge an overrun occurs: set wins.
  - rd and wr together at the same address: the write is performed and data_out shows the pre-write value.
- ready = 1 when a TXDATA write would be accepted.
- FSM states:
  - IDLE: tx=1. Exits on an accepted write.
  - START: tx=0 for BAUD_DIV clocks, then DATA.
  - DATA: 8 bits, LSB first, BAUD_DIV clocks each; bit counter 0..7; after bit 7 goes to STOP.
  - STOP: tx=1 for BAUD_DIV clocks. Then returns to IDLE (busy=0 on the same edge), or goes straight to START if a byte is pending.
- Baud counter: loads BAUD_DIV-1 on every state entry and counts down; the bit ends when it reaches 0. No wrap drift.
- Frame length is exactly 10*BAUD_DIV clocks.

Optional Feature:
- Macro SIMPLEZ_TX_HOLD_EN.
- Defined:
  - One-entry hold register; ready = !hold_full.
  - A write while busy with the hold register empty fills it, with no overrun.
  - At STOP end a held byte starts the next START with no idle gap; the hold register empties.
  - Write with hold full: dropped, overrun=1.
- Undefined:
  - ready = !busy; any write while busy is dropped with overrun=1.

Decomposition:
- Shared package simplez_pkg:
  - ADDRW, DATAW.
  - Opcode localparams (ST..HALT).
  - I/O map constants (ADDR_TXDATA, ADDR_TXSTAT).
  - FSM state encoding for this block: IDLE=0, START=1, DATA=2, STOP=3, 2 bits.
- Sub-module simplez_baud_tick:
  - Inputs: load and en.
  - Output: tick when the count reaches 0.
  - Parameterised by BAUD_DIV.
- Decode, registers and FSM stay in the top.

Test Plan (BAUD_DIV=4):
- Reset with rstn=0 for 2 edges -> tx=1, busy=0, data_out=0, hit=0; read TXSTAT -> data_out=12'h001 one edge later.
- Write 12'hF55 to 508 -> bytes sent 0x55; tx sequence per 4 clocks is 0,1,0,1,0,1,0,1,0,1; busy high exactly 40 clocks; read 508 -> 12'h055.
- Macro off: write 0x41 then 0x42 10 clocks later -> only 0x41 sent; status reads 12'h002 during the frame, 12'h003 after; write 509 -> 12'h001.
- Macro on: write 0x41, 0x42, 0x43 back-to-back during the frame -> 0x41 then 0x42 sent with no idle gap (80 clocks busy); 0x43 dropped; overrun=1.
- rstn=0 at clock 15 of a frame -> tx=1 after that edge, busy=0; a new write 0x7E transmits correctly.
- rd to 507 and 510 -> hit=0, data_out unchanged; wr to 510 -> no frame starts, tx stays 1.
